uart_rx_16os: RTL and testbench

UART receiver for 8N1 frames. It consumes the 16x-oversampling baud tick (9600*16 Hz from a 100 MHz system clock) and recovers serial data from the rx pin. The start bit is centre-aligned and each data/stop bit is sampled mid-bit. It sits between the board rx pin and the command/FIFO logic: one byte plus a one-cycle done strobe per frame, with a framing-error flag.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_16os.sv | 124 ++++++++++++
 tb/tb_uart_rx_16os.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, also used by the tick generator and TX.
package uart_pkg;

    localparam int SYS_CLK    = 100_000_000;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int HALF_BIT   = OVERSAMPLE / 2 - 1;
    // System clocks per oversample tick (100 MHz / 153.6 kHz, truncated).
    localparam int TICK_DIV   = SYS_CLK / (BAUD * OVERSAMPLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_16os.sv
// 8N1 UART receiver on a 16x oversample tick: centre-aligned start check, mid-bit sampling.
module uart_rx_16os #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);
    import uart_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [TICK_W-1:0]    tick_cnt, tick_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 done_nxt, ferr_nxt;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= data_nxt;
            rx_done   <= done_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        ferr_nxt  = frame_err;
        done_nxt  = 1'b0;

        case (state)
            // A tick coinciding with the falling-edge detection is deliberately not counted.
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                end
            end
            START: begin
                if (b_tick) begin
                    if (tick_cnt == TICK_HALF) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                        tick_nxt  = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
                if (b_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        data_nxt  = shift_reg;
                        ferr_nxt  = ~rx_s;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_16os.sv
// Bench for uart_rx_16os: serial frames driven from a frame-level model, received bytes scoreboarded.
module tb_uart_rx_16os;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_busy, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_div = 0;
    int cyc = 0;
    int cur_lo = 0, cur_hi = 0, last_hi = 0;
    int lo_runs[$];

    logic [7:0] got_data[$];
    logic       got_ferr[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_ferr[$];

    uart_rx_16os dut (
        .clk       (clk),
        .reset     (reset),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Tick source: tick_div clks per tick, 1 = stuck high, 0 = off.
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            if (tick_div <= 0) begin
                b_tick = 1'b0;
                tcnt   = 0;
            end else begin
                tcnt   = (tcnt + 1) % tick_div;
                b_tick = (tcnt == 0);
            end
        end
    end

    // Output monitor: logs every rx_done and the busy high/low run lengths.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rx_done === 1'b1) begin
                got_data.push_back(rx_data);
                got_ferr.push_back(frame_err);
                got_cyc.push_back(cyc);
            end
            if (rx_busy === 1'b1) begin
                if (cur_lo > 0) lo_runs.push_back(cur_lo);
                cur_lo = 0;
                cur_hi++;
            end else begin
                if (cur_hi > 0) last_hi = cur_hi;
                cur_hi = 0;
                cur_lo++;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic hold_rx(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_case();
        got_data.delete(); got_ferr.delete(); got_cyc.delete();
        exp_data.delete(); exp_ferr.delete();
        lo_runs.delete();
        last_hi = 0;
    endtask

    // One 8N1 frame at the current tick rate; a bad stop bit is low across its centre only.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        int bclk;
        bclk = OVERSAMPLE * tick_div;
        exp_data.push_back(b);
        exp_ferr.push_back(!stop_ok);
        hold_rx(1'b0, bclk);
        for (int i = 0; i < 8; i++) hold_rx(b[i], bclk);
        if (stop_ok) begin
            hold_rx(1'b1, bclk);
        end else begin
            hold_rx(1'b0, 10 * tick_div);
            hold_rx(1'b1, 6 * tick_div);
        end
    endtask

    task automatic test_reset();
        tick_div = 0;
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", rx_done); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: busy got %b want 0", rx_busy); end
    endtask

    task automatic test_single_0x55();
        int t0, lat, d;
        d = 5;
        tick_div = d;
        clear_case();
        hold_rx(1'b1, 40);
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        hold_rx(1'b1, 32 * d);
        n_cmp++; if (got_data.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_data.size()); end
        if (got_data.size() >= 1) begin
            lat = got_cyc[0] - t0;
            n_cmp++; if (got_data[0] !== 8'h55) begin n_bad++; $display("FAIL single_data: got %h want 55", got_data[0]); end
            n_cmp++; if (got_ferr[0] !== 1'b0) begin n_bad++; $display("FAIL single_ferr: got %b want 0", got_ferr[0]); end
            n_cmp++;
            if (lat < 152 * d - d - 6 || lat > 152 * d + d + 6) begin
                n_bad++; $display("FAIL single_latency: got %0d clks want %0d +/- %0d", lat, 152 * d, d + 6);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick_div = 1;
        clear_case();
        hold_rx(1'b1, 20);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        hold_rx(1'b1, 40);
        n_cmp++; if (got_data.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", got_data.size()); end
        if (got_data.size() >= 2) begin
            n_cmp++; if (got_data[0] !== 8'hA3) begin n_bad++; $display("FAIL b2b_data0: got %h want a3", got_data[0]); end
            n_cmp++; if (got_data[1] !== 8'h0F) begin n_bad++; $display("FAIL b2b_data1: got %h want 0f", got_data[1]); end
            n_cmp++; if (got_cyc[1] - got_cyc[0] !== 160) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 160", got_cyc[1] - got_cyc[0]); end
        end
        n_cmp++;
        if (lo_runs.size() < 2) begin
            n_bad++; $display("FAIL b2b_gap: got %0d busy rises want 2", lo_runs.size());
        end else if (lo_runs[1] > 8) begin
            n_bad++; $display("FAIL b2b_gap: busy low %0d clks want <=8", lo_runs[1]);
        end
    endtask

    task automatic test_glitch();
        tick_div = 1;
        clear_case();
        hold_rx(1'b1, 20);
        hold_rx(1'b0, 5);
        hold_rx(1'b1, 40);
        n_cmp++; if (got_data.size() !== 0) begin n_bad++; $display("FAIL glitch_done: got %0d pulses want 0", got_data.size()); end
        n_cmp++; if (last_hi !== 8) begin n_bad++; $display("FAIL glitch_busy_len: got %0d clks want 8", last_hi); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: busy got %b want 0", rx_busy); end
    endtask

    task automatic test_frame_err();
        tick_div = 2;
        clear_case();
        hold_rx(1'b1, 20);
        send_frame(8'hFF, 1'b0);
        hold_rx(1'b1, 32 * tick_div);
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_held: got %b want 1", frame_err); end
        send_frame(8'h12, 1'b1);
        hold_rx(1'b1, 32 * tick_div);
        n_cmp++; if (got_data.size() !== 2) begin n_bad++; $display("FAIL ferr_count: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_ferr[i] !== exp_ferr[i]) begin
                n_bad++; $display("FAIL ferr_frame%0d: got %h/%b want %h/%b", i, got_data[i], got_ferr[i], exp_data[i], exp_ferr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h3C;
        tick_div = 1;
        clear_case();
        hold_rx(1'b1, 20);
        hold_rx(1'b0, 16);
        for (int i = 0; i < 4; i++) hold_rx(b[i], 16);
        hold_rx(b[4], 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", rx_busy); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", rx_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
        hold_rx(1'b1, 200);
        n_cmp++; if (got_data.size() !== 0) begin n_bad++; $display("FAIL midrst_nodone: got %0d pulses want 0", got_data.size()); end
        send_frame(b, 1'b1);
        hold_rx(1'b1, 40);
        n_cmp++;
        if (got_data.size() !== 1) begin
            n_bad++; $display("FAIL midrst_refrm: got %0d pulses want 1", got_data.size());
        end else if (got_data[0] !== 8'h3C || got_ferr[0] !== 1'b0) begin
            n_bad++; $display("FAIL midrst_refrm: got %h/%b want 3c/0", got_data[0], got_ferr[0]);
        end
    endtask

    task automatic test_break();
        tick_div = 1;
        clear_case();
        hold_rx(1'b1, 20);
        rx = 1'b0;
        for (int k = 0; k < 700 && got_data.size() < 3; k++) @(negedge clk);
        hold_rx(1'b1, 100);
        n_cmp++; if (got_data.size() !== 3) begin n_bad++; $display("FAIL break_count: got %0d want 3", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 8'h00 || got_ferr[i] !== 1'b1) begin
                n_bad++; $display("FAIL break_frame%0d: got %h/%b want 00/1", i, got_data[i], got_ferr[i]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_cmp++;
            if (got_cyc[i] - got_cyc[i-1] < 152 || got_cyc[i] - got_cyc[i-1] > 156) begin
                n_bad++; $display("FAIL break_period%0d: got %0d clks want 152..156", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        for (int i = 1; i < 3 && i < lo_runs.size(); i++) begin
            n_cmp++;
            if (lo_runs[i] > 2) begin
                n_bad++; $display("FAIL break_busy%0d: busy low %0d clks want <=2", i, lo_runs[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_case();
        hold_rx(1'b1, 20);
        for (int f = 0; f < 10; f++) begin
            tick_div = $urandom_range(1, 4);
            hold_rx(1'b1, 4);
            send_frame(8'($urandom), ($urandom_range(0, 3) != 0));
            hold_rx(1'b1, OVERSAMPLE * tick_div * $urandom_range(1, 3));
        end
        hold_rx(1'b1, 100);
        n_cmp++;
        if (got_data.size() !== exp_data.size()) begin
            n_bad++; $display("FAIL rand_count: got %0d want %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_ferr[i] !== exp_ferr[i]) begin
                n_bad++; $display("FAIL rand_frame%0d: got %h/%b want %h/%b", i, got_data[i], got_ferr[i], exp_data[i], exp_ferr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_0x55();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
